// File: rtl/lpc_autocorrelation_if.sv
// Handshake and memory-port bundle between the encoder control/memories and the
// LPC autocorrelation stage.
interface lpc_autocorrelation_if #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned R_ADDR_W = 4
);
  logic                       start;
  logic [ADDR_W-1:0]          x_raddr;
  logic signed [DATA_W-1:0]   x_rdata;
  logic                       r_we;
  logic [R_ADDR_W-1:0]        r_waddr;
  logic signed [ACC_W-1:0]    r_wdata;
  logic                       busy;
  logic                       ready_autocorrelation;

  modport master (
    output start, x_rdata,
    input  x_raddr, r_we, r_waddr, r_wdata, busy, ready_autocorrelation
  );

  modport slave (
    input  start, x_rdata,
    output x_raddr, r_we, r_waddr, r_wdata, busy, ready_autocorrelation
  );
endinterface

// File: rtl/lpc_autocorrelation.sv
// Autocorrelation lags R[0..ORDER] of one PCM frame using a single sequential MAC.
// Define LPC_AUTOCORR_SAT_EN for a saturating (sticky per lag) accumulator.
module lpc_autocorrelation #(
  parameter int unsigned FRAME_LEN = 240,
  parameter int unsigned ORDER     = 10,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned R_ADDR_W  = 4
) (
  input logic                clk,
  input logic                reset,
  lpc_autocorrelation_if.slave bus
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic [ADDR_W-1:0]   LAST_N = ADDR_W'(FRAME_LEN - 1);
  localparam logic [R_ADDR_W-1:0] LAST_K = R_ADDR_W'(ORDER);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, DRAIN, WRITE, DONE} state_t;

  state_t                   state, state_nx;
  logic [R_ADDR_W-1:0]      k, k_nx;
  logic [ADDR_W-1:0]        n, n_nx;
  logic signed [ACC_W-1:0]  acc, acc_nx, acc_add;
  logic signed [DATA_W-1:0] xa, xa_nx;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;

  logic [ADDR_W-1:0]        raddr_q, raddr_nx;
  logic                     we_q, we_nx;
  logic [R_ADDR_W-1:0]      waddr_q, waddr_nx;
  logic signed [ACC_W-1:0]  wdata_q, wdata_nx;
  logic                     busy_q, busy_nx;
  logic                     ready_q, ready_nx;

  assign prod     = PROD_W'(xa) * PROD_W'(bus.x_rdata);
  assign prod_ext = ACC_W'(prod);
  assign sum      = acc + prod_ext;

`ifdef LPC_AUTOCORR_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic sat, sat_nx, sat_add, ovf;

  // Once a lag has hit a rail it stays there until WRITE clears the accumulator.
  always_comb begin
    ovf     = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    sat_add = sat | ovf;
    if (sat)      acc_add = acc;
    else if (ovf) acc_add = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
    else          acc_add = sum;
  end
`else
  assign acc_add = sum;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      k       <= '0;
      n       <= '0;
      acc     <= '0;
      xa      <= '0;
      raddr_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
`ifdef LPC_AUTOCORR_SAT_EN
      sat     <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      k       <= k_nx;
      n       <= n_nx;
      acc     <= acc_nx;
      xa      <= xa_nx;
      raddr_q <= raddr_nx;
      we_q    <= we_nx;
      waddr_q <= waddr_nx;
      wdata_q <= wdata_nx;
      busy_q  <= busy_nx;
      ready_q <= ready_nx;
`ifdef LPC_AUTOCORR_SAT_EN
      sat     <= sat_nx;
`endif
    end
  end

  // Next-state logic; outputs are computed one cycle early so they land registered.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    n_nx     = n;
    acc_nx   = acc;
    xa_nx    = xa;
    raddr_nx = raddr_q;
    we_nx    = 1'b0;
    waddr_nx = waddr_q;
    wdata_nx = wdata_q;
    busy_nx  = busy_q;
    ready_nx = ready_q;
`ifdef LPC_AUTOCORR_SAT_EN
    sat_nx   = sat;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          k_nx     = '0;
          n_nx     = '0;
          acc_nx   = '0;
          ready_nx = 1'b0;
          busy_nx  = 1'b1;
          raddr_nx = '0;
`ifdef LPC_AUTOCORR_SAT_EN
          sat_nx   = 1'b0;
`endif
          state_nx = RD_A;
        end
      end
      RD_A: begin
        // First RD_A of a lag (n == k) has no product in flight yet.
        if (n != ADDR_W'(k)) begin
          acc_nx = acc_add;
`ifdef LPC_AUTOCORR_SAT_EN
          sat_nx = sat_add;
`endif
        end
        raddr_nx = n - ADDR_W'(k);
        state_nx = RD_B;
      end
      RD_B: begin
        xa_nx = bus.x_rdata;
        if (n == LAST_N) begin
          state_nx = DRAIN;
        end else begin
          n_nx     = n + ADDR_W'(1);
          raddr_nx = n + ADDR_W'(1);
          state_nx = RD_A;
        end
      end
      DRAIN: begin
        acc_nx   = acc_add;
`ifdef LPC_AUTOCORR_SAT_EN
        sat_nx   = sat_add;
`endif
        we_nx    = 1'b1;
        waddr_nx = k;
        wdata_nx = acc_add;
        state_nx = WRITE;
      end
      WRITE: begin
        acc_nx = '0;
`ifdef LPC_AUTOCORR_SAT_EN
        sat_nx = 1'b0;
`endif
        if (k == LAST_K) begin
          state_nx = DONE;
        end else begin
          k_nx     = k + R_ADDR_W'(1);
          n_nx     = ADDR_W'(k) + ADDR_W'(1);
          raddr_nx = ADDR_W'(k) + ADDR_W'(1);
          state_nx = RD_A;
        end
      end
      DONE: begin
        busy_nx  = 1'b0;
        ready_nx = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.x_raddr               = raddr_q;
  assign bus.r_we                  = we_q;
  assign bus.r_waddr               = waddr_q;
  assign bus.r_wdata               = wdata_q;
  assign bus.busy                  = busy_q;
  assign bus.ready_autocorrelation = ready_q;

endmodule

// File: tb/tb_lpc_autocorrelation.sv
// Directed bench for lpc_autocorrelation: table-driven R[k] checks over several frames
// plus hand-written sequences for restart, reset abort, back-to-back and overflow.
module tb_lpc_autocorrelation;

  localparam int LATENCY = 5193;
  localparam int BUDGET  = 8000;

  logic clk;
  logic reset;

  lpc_autocorrelation_if #(.ADDR_W(8), .DATA_W(16), .ACC_W(40), .R_ADDR_W(4)) bus ();
  lpc_autocorrelation_if #(.ADDR_W(8), .DATA_W(16), .ACC_W(34), .R_ADDR_W(4)) bus2 ();

  lpc_autocorrelation #(
    .FRAME_LEN(240), .ORDER(10), .DATA_W(16), .ACC_W(40), .ADDR_W(8), .R_ADDR_W(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  lpc_autocorrelation #(
    .FRAME_LEN(240), .ORDER(10), .DATA_W(16), .ACC_W(34), .ADDR_W(8), .R_ADDR_W(4)
  ) dut_ovf (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous sample RAM models.
  logic signed [15:0] mem [0:255];
  always @(posedge clk) bus.x_rdata <= mem[bus.x_raddr];
  always @(posedge clk) bus2.x_rdata <= 16'sh8000;

  // Log every R-memory write.
  logic [3:0] wa_q [$];
  longint     wd_q [$];
  logic [3:0] wa2_q [$];
  longint     wd2_q [$];
  always @(negedge clk) begin
    if (bus.r_we) begin
      wa_q.push_back(bus.r_waddr);
      wd_q.push_back(longint'(bus.r_wdata));
    end
    if (bus2.r_we) begin
      wa2_q.push_back(bus2.r_waddr);
      wd2_q.push_back(longint'(bus2.r_wdata));
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int     kind;
    int     lag;
    longint exp;
  } vec_t;
  vec_t vecs [11];

  task automatic fill_mem(input int kind);
    for (int i = 0; i < 256; i++) begin
      case (kind)
        0:       mem[i] = (i == 0) ? 16'sd1000 : 16'sd0;
        1:       mem[i] = 16'sd1;
        default: mem[i] = (i % 2 == 0) ? 16'sd100 : -16'sd100;
      endcase
    end
  endtask

  // Entered and left at a negedge; start is raised immediately.
  task automatic run_frame(input int kind, input bit poke_start);
    int cycles;
    int base;
    fill_mem(kind);
    base = wa_q.size();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check($sformatf("k%0d_ready_low_after_start", kind), longint'(bus.ready_autocorrelation), 0);
    check($sformatf("k%0d_busy_after_start", kind), longint'(bus.busy), 1);
    cycles = 0;
    while (!bus.ready_autocorrelation && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
      bus.start = (poke_start && cycles == 100);
    end
    bus.start = 1'b0;
    check($sformatf("k%0d_latency", kind), longint'(cycles), LATENCY);
    check($sformatf("k%0d_write_count", kind), longint'(wa_q.size() - base), 11);
    for (int i = 0; i < 11; i++) begin
      if (base + i < wa_q.size())
        check($sformatf("k%0d_waddr%0d", kind, i), longint'(wa_q[base+i]), longint'(i));
    end
    for (int v = 0; v < 11; v++) begin
      if (vecs[v].kind == kind) begin
        check($sformatf("k%0d_R%0d", kind, vecs[v].lag),
              (base + vecs[v].lag < wd_q.size()) ? wd_q[base + vecs[v].lag] : -64'sd1,
              vecs[v].exp);
      end
    end
  endtask

  initial begin
    int     cycles;
    int     wn;
    int     b2;
    longint exp_r0, exp_r10;

    vecs[0]  = '{0, 0, 1000000};
    vecs[1]  = '{0, 1, 0};
    vecs[2]  = '{0, 10, 0};
    vecs[3]  = '{1, 0, 240};
    vecs[4]  = '{1, 1, 239};
    vecs[5]  = '{1, 10, 230};
    vecs[6]  = '{2, 0, 2400000};
    vecs[7]  = '{2, 1, -2390000};
    vecs[8]  = '{2, 2, 2380000};
    vecs[9]  = '{2, 9, -2310000};
    vecs[10] = '{2, 10, 2300000};

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus2.start = 1'b0;
    fill_mem(0);
    repeat (3) @(negedge clk);
    check("rst_x_raddr", longint'(bus.x_raddr), 0);
    check("rst_r_we", longint'(bus.r_we), 0);
    check("rst_r_waddr", longint'(bus.r_waddr), 0);
    check("rst_r_wdata", longint'(bus.r_wdata), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_ready", longint'(bus.ready_autocorrelation), 0);
    check("rst_ovf_ready", longint'(bus2.ready_autocorrelation), 0);
    reset = 1'b0;
    @(negedge clk);

    // Impulse, constant (with a stray start mid-run), then alternating back-to-back.
    run_frame(0, 1'b0);
    run_frame(1, 1'b1);
    run_frame(2, 1'b0);

    // Reset at cycle 1000 of a run aborts with no further writes.
    @(negedge clk);
    fill_mem(1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cycles = 1;
    while (cycles < 1000) begin
      @(negedge clk);
      cycles++;
    end
    reset = 1'b1;
    @(negedge clk);
    wn = wa_q.size();
    check("abort_x_raddr", longint'(bus.x_raddr), 0);
    check("abort_r_we", longint'(bus.r_we), 0);
    check("abort_r_waddr", longint'(bus.r_waddr), 0);
    check("abort_r_wdata", longint'(bus.r_wdata), 0);
    check("abort_busy", longint'(bus.busy), 0);
    check("abort_ready", longint'(bus.ready_autocorrelation), 0);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check("abort_no_more_writes", longint'(wa_q.size()), longint'(wn));
    check("abort_still_idle", longint'(bus.busy), 0);

    // Normal operation resumes after the abort.
    run_frame(2, 1'b0);

    // Overflow frame on the 34-bit accumulator: every product is 2^30.
`ifdef LPC_AUTOCORR_SAT_EN
    exp_r0  = 64'sd8589934591;
    exp_r10 = 64'sd8589934591;
`else
    exp_r0  = 64'sd0;
    exp_r10 = 64'sd6442450944;
`endif
    b2 = wd2_q.size();
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    cycles = 0;
    while (!bus2.ready_autocorrelation && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
    end
    check("ovf_latency", longint'(cycles), LATENCY);
    check("ovf_write_count", longint'(wd2_q.size() - b2), 11);
    check("ovf_R0", (b2 < wd2_q.size()) ? wd2_q[b2] : -64'sd1, exp_r0);
    check("ovf_R10", (b2 + 10 < wd2_q.size()) ? wd2_q[b2+10] : -64'sd1, exp_r10);
    check("ovf_waddr10", (b2 + 10 < wa2_q.size()) ? longint'(wa2_q[b2+10]) : -64'sd1, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lpc_autocorrelation.md
Name: lpc_autocorrelation

Overview:
- Upstream stage of the LPC encoder. Reads one frame of signed PCM samples from the frame sample memory.
- Computes autocorrelation lags R[0..ORDER] with a single sequential MAC and writes them into the R memory that the Levinson-Durbin stage consumes.
- Drives ready_autocorrelation to the encoder control FSM, which holds its x_raddr mux on this block while it waits.

Parameters:
- FRAME_LEN, 240, samples per frame N; must satisfy ORDER < FRAME_LEN.
- ORDER, 10, highest lag P; P+1 R values are produced.
- DATA_W, 16, sample width, signed two's complement.
- ACC_W, 40, accumulator and R output width, signed; must be >= 2*DATA_W.
- ADDR_W, 8, sample address width; 2^ADDR_W >= FRAME_LEN.
- R_ADDR_W, 4, R memory address width; 2^R_ADDR_W > ORDER.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin frame; sampled only in IDLE
- x_raddr  out  ADDR_W  sample memory read address
- x_rdata  in  DATA_W  sample memory read data; synchronous RAM, valid 1 cycle after x_raddr
- r_we  out  1  R memory write enable
- r_waddr  out  R_ADDR_W  R memory write address (lag k)
- r_wdata  out  ACC_W  R[k] value
- busy  out  1  high from the cycle after start is accepted until the final write
- ready_autocorrelation  out  1  frame result complete (level)

Behaviour:
- Reset values: state IDLE, x_raddr=0, r_we=0, r_waddr=0, r_wdata=0, busy=0, ready_autocorrelation=0. Accumulator, lag counter k and index counter n are cleared.
- Reset mid-operation: abort on the next edge, return to reset values. No partial write follows.
- R[k] = sum over n=k..N-1 of x[n]*x[n-k].
  - Each product is signed DATA_W x DATA_W, sign-extended to ACC_W.
  - The accumulator wraps modulo 2^ACC_W unless the optional feature is enabled.
- States: IDLE, RD_A, RD_B, DRAIN, WRITE, DONE.
- IDLE:
  - If start=1: k<=0, n<=0, acc<=0, ready_autocorrelation<=0, busy<=1, go to RD_A.
  - ready is therefore already low in the first cycle the control FSM waits on it.
- RD_A:
  - x_raddr=n.
  - If a product is pending (not the first product of the lag): acc += xa*x_rdata, where x_rdata is x[n_prev-k].
  - Go to RD_B.
- RD_B:
  - x_raddr=n-k; xa <= x_rdata, which is x[n].
  - If n==N-1, go to DRAIN; else n<=n+1 and go to RD_A.
- DRAIN: acc += xa*x_rdata (the final product); go to WRITE.
- WRITE:
  - r_we=1, r_waddr=k, r_wdata=acc. Clear acc.
  - If k==ORDER, go to DONE; else k<=k+1, n<=k+1, go to RD_A.
- DONE: busy<=0, ready_autocorrelation<=1, go to IDLE.
- ready_autocorrelation stays high until the next accepted start (cleared on that edge) or reset.
- start while not in IDLE is ignored, with no effect on results.
- Latency per lag: 2*(N-k)+2 cycles.
  - Total from start edge to ready high = 1 + sum_{k=0..P}(2(N-k)+2).
  - For the defaults this is 5193 cycles; there are exactly ORDER+1 r_we pulses.
- x_raddr holds its last value in IDLE/DONE. r_we is high only in WRITE.

Optional Feature:
- Macro LPC_AUTOCORR_SAT_EN.
- Defined: each accumulate saturates to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) on signed overflow. Saturation is sticky for that lag until WRITE clears acc.
- Undefined: two's-complement wrap. No extra logic.
- Timing is identical in both builds.

Test Plan:
- Impulse: x[0]=1000, all other samples 0; pulse start -> R[0]=1000000, R[1..10]=0, ready high 5193 cycles after the start edge, 11 r_we pulses at addresses 0..10.
- Constant: all x=1 -> R[k]=240-k (240, 239, ..., 230).
- Alternating: x[n]=(-1)^n*100 -> R[k]=(-1)^k*10000*(240-k), e.g. R[1]=-2390000.
- Overflow, ACC_W=34, all x=-32768:
  - Wrapped build: R[0] = 240*2^30 mod 2^34, signed.
  - LPC_AUTOCORR_SAT_EN build: R[0]=2^33-1.
- start pulsed again at cycle 100 of a run -> ignored, results and timing unchanged. reset asserted at cycle 1000 -> all outputs 0 next cycle, no further r_we.
- Back-to-back: start one cycle after ready rises -> ready drops on that edge, second frame's results correct.
